// File: rtl/calc_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared constants and types for the calculator op sequencer:
//            default operand width, one-hot operator encodings and the
//            sequencer state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MUL  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } seq_state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_sequencer_if
// Purpose  : Request/response bundle between the input controller (master)
//            and the arithmetic sequencer (slave).
// Signals  : start, op, operand_a, operand_b  - request (master -> slave)
//            busy, done, result, overflow, op_error - response (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface calc_op_sequencer_if
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             op_error;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, result, overflow, op_error
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, result, overflow, op_error
  );

endinterface : calc_op_sequencer_if
`default_nettype wire

// File: rtl/calc_op_sequencer_shift_add_mul_dp.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mul_dp
// Purpose  : Unsigned serial shift-add multiplier datapath. One partial
//            product is accumulated per i_step; after WIDTH steps o_product
//            holds the full 2*WIDTH-bit product. Sequencing is external.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_clr          - load operands and clear the accumulator
//            i_step         - perform one shift-add step
//            i_mcand/i_mplier - unsigned multiplicand / multiplier
//            o_product      - accumulated product
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mul_dp #(
  parameter int WIDTH = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_clr,
  input  wire logic                 i_step,
  input  wire logic [WIDTH-1:0]     i_mcand,
  input  wire logic [WIDTH-1:0]     i_mplier,
  output logic      [2*WIDTH-1:0]   o_product
);

  logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   r_mplier;  // multiplier, LSB selects the partial product
  logic [2*WIDTH-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_clr) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_acc    <= '0;
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_product = r_acc;

endmodule : shift_add_mul_dp
`default_nettype wire

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_sequencer
// Purpose  : Multi-cycle arithmetic sequencer. Single-cycle add/subtract or
//            WIDTH-cycle serial multiply on signed operands, returning a
//            wrapped WIDTH-bit result with overflow and illegal-op flags.
// Ports    : clk  - rising-edge clock
//            RST  - synchronous active-high reset
//            bus  - calc_op_sequencer_if.slave (start/op/operands in,
//                   busy/done/result/overflow/op_error out)
// Revision : 1.0 - initial release
// ============================================================================
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             RST,
  calc_op_sequencer_if.slave    bus
);

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_EXEC = EXEC;
  localparam logic [2:0] S_MUL  = MUL;
  localparam logic [2:0] S_FIX  = FIX;
  localparam logic [2:0] S_DONE = DONE;

  localparam int         CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

  logic [2:0]         r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_sign;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_overflow;
  logic               r_op_error;

  logic               w_mul_start;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_product;
  logic [2*WIDTH-1:0] w_prod_signed;
  logic [WIDTH:0]     w_sum;
  logic               w_addsub_legal;
  logic               w_mul_ovf;

  // Magnitudes as unsigned values; -2^(W-1) negates to itself, which read
  // unsigned is exactly 2^(W-1).
  assign w_abs_a = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
  assign w_abs_b = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

  assign w_mul_start = (r_state == S_IDLE) && bus.start && (bus.op == OP_MUL);

  shift_add_mul_dp #(
    .WIDTH     (WIDTH)
  ) u_mul_dp (
    .clk       (clk),
    .rst       (RST),
    .i_clr     (w_mul_start),
    .i_step    (r_state == S_MUL),
    .i_mcand   (w_abs_a),
    .i_mplier  (w_abs_b),
    .o_product (w_product)
  );

  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign w_addsub_legal = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_sum = (r_op == OP_SUB) ? ({r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b})
                                  : ({r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b});

  // Zero product stays positive so a negative sign never yields -0.
  assign w_prod_signed = (r_sign && (|w_product)) ? -w_product : w_product;

  // In range iff bits [2W-1:W-1] are all equal (pure sign extension).
  assign w_mul_ovf = !((&w_prod_signed[2*WIDTH-1:WIDTH-1]) ||
                       (~|w_prod_signed[2*WIDTH-1:WIDTH-1]));

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sign     <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_op_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op   <= bus.op;
            r_a    <= bus.operand_a;
            r_b    <= bus.operand_b;
            r_sign <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
            r_cnt  <= '0;
            r_state <= (bus.op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_addsub_legal) begin
            r_result   <= w_sum[WIDTH-1:0];
            r_overflow <= w_sum[WIDTH] ^ w_sum[WIDTH-1];
            r_op_error <= 1'b0;
          end else begin
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_op_error <= 1'b1;
          end
          r_state <= S_DONE;
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST_STEP) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result   <= w_prod_signed[WIDTH-1:0];
          r_overflow <= w_mul_ovf;
          r_op_error <= 1'b0;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;
  assign bus.op_error = r_op_error;

endmodule : calc_op_sequencer
`default_nettype wire

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Multi-cycle arithmetic sequencer placed between the calculator input controller and the display path. It accepts two signed operands and a one-hot operator on a start pulse, and runs a single-cycle add or subtract, or a serial shift-add multiply. It then returns a WIDTH-bit signed result with overflow and error flags through a start/busy/done handshake.

Parameters:
WIDTH, 16, operand and result width in bits (two's complement).

Ports:
clk  in  1  system clock, rising-edge.
RST  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
op  in  3  one-hot operator: 3'b001 add, 3'b010 subtract, 3'b100 multiply.
operand_a  in  WIDTH  signed first operand.
operand_b  in  WIDTH  signed second operand.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when result and flags are updated.
result  out  WIDTH  signed result, low WIDTH bits of the true result (wraps on overflow).
overflow  out  1  true result is outside the signed WIDTH range.
op_error  out  1  op was not one of the three legal encodings.

Behaviour:
- Reset: on an RST-high edge the state returns to IDLE. busy=0, done=0, result=0, overflow=0, op_error=0. RST overrides everything, including mid-operation; no done is produced for an aborted job.
- States: IDLE, EXEC, MUL, FIX, DONE.
- IDLE, start=1:
  - Latch op, operand_a and operand_b.
  - Legal add/sub, or illegal op: go to EXEC.
  - Multiply: store |a| and |b| as unsigned WIDTH-bit values (|-2^(W-1)| = 2^(W-1) fits), store sign = a[W-1]^b[W-1], clear the accumulator and iteration counter, go to MUL.
- EXEC:
  - Compute a±b in WIDTH+1 bits. overflow = top two bits differ.
  - Illegal op: result=0, op_error=1, overflow=0.
  - Go to DONE.
- MUL:
  - One shift-add step per cycle for exactly WIDTH cycles, forming a 2*WIDTH-bit unsigned product.
  - Counter counts 0..WIDTH-1; go to FIX after the last step.
- FIX:
  - If sign=1 and the product is nonzero, negate in 2*WIDTH bits.
  - result = low WIDTH bits.
  - overflow = the 2*WIDTH-bit signed product is not in [-2^(W-1), 2^(W-1)-1].
  - Go to DONE.
- DONE: done=1 for this cycle only; next state IDLE.
- Output timing: result, overflow and op_error are registered on entry to DONE. They hold their values until the next DONE or reset.
- Latency, with start high in IDLE cycle k:
  - add/sub/illegal: done high in cycle k+2.
  - multiply: done high in cycle k+WIDTH+2 (k+18 at WIDTH=16).
- Back-to-back: start is accepted in the first IDLE cycle after DONE. The earliest next done for add is 3 cycles after the previous one.
- start while busy (including the DONE cycle): ignored, never queued. Operand and op changes during busy have no effect.
- Zero operand in multiply: product 0, result 0, never negative zero, overflow=0.

Decomposition:
- Package calc_pkg:
  - op encodings OP_ADD=3'b001, OP_SUB=3'b010, OP_MUL=3'b100.
  - state enum seq_state_t {IDLE, EXEC, MUL, FIX, DONE}.
  - default WIDTH constant.
- Sub-module shift_add_mul_dp: unsigned serial multiplier datapath (multiplicand, multiplier shift register, 2*WIDTH accumulator, step enable, clear). The sequencer owns the counter, sign handling and the FSM.

Test Plan:
- Reset, then add 2+3 with start at cycle k -> done only in k+2, result=5, overflow=0, busy high k+1..k+2. Then 32767+(-32768) -> result=-1, overflow=0.
- Subtract -3-(-5) -> result=2, overflow=0. Then 32767-(-1) -> result=16'h8000, overflow=1.
- Multiply, each with done at exactly k+18:
  - -3*-6 -> result=18, overflow=0.
  - 128*256 -> result=16'h8000, overflow=1.
  - -32768*1 -> result=16'h8000, overflow=0.
  - -12*3000 -> result=16'h7360, overflow=1.
  - 0*100 -> result=0.
- Start multiply 4*3 at k, then pulse start with add 1+1 at k+5 -> single done at k+18, result=12. No second done.
- Start multiply, assert RST at k+8 -> busy=0 and all outputs 0 the next cycle, no done. A new add 1+1 afterwards -> result=2 two cycles later.
- op=3'b011 -> done at k+2, op_error=1, result=0, overflow=0. A following legal add clears op_error to 0.
